// File: rtl/hopper_ctrl_pkg.sv
// hopper_ctrl_pkg: shared game-state, facing and hopper FSM enums.
package hopper_ctrl_pkg;
    typedef enum logic [1:0] {MENU = 2'd0, PLAYING = 2'd1, DEAD = 2'd2, WIN = 2'd3} game_state_t;
    typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} face_dir_t;
    typedef enum logic [1:0] {IDLE = 2'd0, HOP = 2'd1, RESPAWN = 2'd2, GAMEOVER = 2'd3} hop_state_t;
endpackage

// File: rtl/hopper_ctrl_debounce.sv
// hopper_ctrl_debounce: synchronises one button and emits a one-cycle tick
// once a new pressed level has been stable for STABLE cycles.
module hopper_ctrl_debounce #(
    parameter int STABLE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic tick
);
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE - 1);
    logic [1:0] sync;
    logic level;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= '0;
            tick  <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            tick <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CMAX) begin
                level <= sync[1];
                cnt   <= '0;
                tick  <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/hopper_ctrl.sv
// hopper_ctrl: grid-hopping sprite controller with lives, riding and respawn.
// Optional HOPPER_BUFFER_EN stores one press made during a hop.
module hopper_ctrl
    import hopper_ctrl_pkg::*;
#(
    parameter int BLOCK          = 32,
    parameter int HOP_FRAMES     = 4,
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int END_Y          = 15,
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 30
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_tick,
    input  logic [1:0]                 state,
    input  logic [9:0]                 init_x,
    input  logic [9:0]                 init_y,
    input  logic [9:0]                 frog_size,
    input  logic [3:0]                 dpad_input,
    input  logic                       collision,
    input  logic                       ride_en,
    input  logic [3:0]                 ride_dx,
    output logic [9:0]                 pos_x,
    output logic [9:0]                 pos_y,
    output logic [1:0]                 facing,
    output logic                       hopping,
    output logic                       reached_end,
    output logic [$clog2(LIVES+1)-1:0] lives,
    output logic                       game_over
);
    localparam int LW = $clog2(LIVES + 1);
    localparam int FW = $clog2(HOP_FRAMES + 1);
    localparam int RW = $clog2(RESPAWN_FRAMES + 1);
    localparam logic [9:0] B = 10'(BLOCK);
    localparam logic [9:0] STEP = 10'(BLOCK / HOP_FRAMES);
    localparam logic [FW-1:0] LAST_F = FW'(HOP_FRAMES - 1);
    localparam logic [RW-1:0] LAST_R = RW'(RESPAWN_FRAMES - 1);

    logic [3:0] tick;
    for (genvar i = 0; i < 4; i++) begin : g_deb
        hopper_ctrl_debounce u_deb (.clk(clk), .reset(reset), .din(dpad_input[i]), .tick(tick[i]));
    end

    hop_state_t cur, n_cur;
    face_dir_t face, n_face, hd, n_hd, pd, st_d, done_d;
    logic [9:0] tx, ty, n_tx, n_ty, n_x, n_y, st_x, st_y;
    logic [FW-1:0] fcnt, n_fc;
    logic [RW-1:0] rcnt, n_rc;
    logic [LW-1:0] n_lives;
    logic n_hop, n_go, n_end, st_go, pv, playing, hop_done, done_v, live;
    logic signed [11:0] ride_x, ride_max;

    assign playing  = state == PLAYING;
    assign pv       = |tick;
    assign pd       = tick[2] ? UP : tick[1] ? DOWN : tick[0] ? LEFT : RIGHT;
    assign hop_done = frame_tick && fcnt == LAST_F;
    assign ride_x   = $signed({2'b00, pos_x}) + 12'(signed'(ride_dx));
    assign ride_max = $signed(12'(SCREEN_W)) - $signed({2'b00, frog_size});
    assign facing   = face;

    function automatic logic legal(face_dir_t d, logic [9:0] x, logic [9:0] y, logic [9:0] fs);
        return d == UP   ? y >= B :
               d == DOWN ? {2'b00, y} + {2'b00, B} + {2'b00, fs} <= 12'(SCREEN_H) :
               d == LEFT ? x >= B :
                           {2'b00, x} + {2'b00, B} + {2'b00, fs} <= 12'(SCREEN_W);
    endfunction

`ifdef HOPPER_BUFFER_EN
    logic bv;
    face_dir_t bd;
    // First press during a hop is kept; it is consumed at completion or dropped on a hit.
    always_ff @(posedge clk) begin
        if (reset || !live) begin
            bv <= 1'b0;
            bd <= UP;
        end else if (playing && cur == HOP) begin
            bv <= !(collision || hop_done) && (bv || pv);
            bd <= bv ? bd : pd;
        end
    end
    assign done_v = bv || pv;
    assign done_d = bv ? bd : pd;
`else
    assign done_v = 1'b0;
    assign done_d = UP;
`endif

    always_ff @(posedge clk) begin
        live <= 1'b1;
        if (reset || !live) begin
            cur         <= IDLE;
            pos_x       <= init_x;
            pos_y       <= init_y;
            face        <= UP;
            hopping     <= 1'b0;
            reached_end <= 1'b0;
            lives       <= LW'(LIVES);
            game_over   <= 1'b0;
            tx          <= init_x;
            ty          <= init_y;
            hd          <= UP;
            fcnt        <= '0;
            rcnt        <= '0;
        end else begin
            cur         <= n_cur;
            pos_x       <= n_x;
            pos_y       <= n_y;
            face        <= n_face;
            hopping     <= n_hop;
            reached_end <= n_end;
            lives       <= n_lives;
            game_over   <= n_go;
            tx          <= n_tx;
            ty          <= n_ty;
            hd          <= n_hd;
            fcnt        <= n_fc;
            rcnt        <= n_rc;
        end
    end

    always_comb begin
        n_cur   = cur;
        n_x     = pos_x;
        n_y     = pos_y;
        n_face  = face;
        n_hop   = hopping;
        n_lives = lives;
        n_go    = game_over;
        n_tx    = tx;
        n_ty    = ty;
        n_hd    = hd;
        n_fc    = fcnt;
        n_rc    = rcnt;
        st_go   = 1'b0;
        st_x    = pos_x;
        st_y    = pos_y;
        st_d    = pd;
        if (playing && collision && (cur == IDLE || cur == HOP)) begin
            n_lives = lives - 1'b1;
            n_x     = init_x;
            n_y     = init_y;
            n_face  = UP;
            n_hop   = 1'b0;
            n_fc    = '0;
            n_rc    = '0;
            n_go    = lives == LW'(1);
            n_cur   = lives == LW'(1) ? GAMEOVER : RESPAWN;
        end else if (playing) begin
            case (cur)
                IDLE: begin
                    if (pv) begin
                        n_face = pd;
                        st_go  = legal(pd, pos_x, pos_y, frog_size);
                    end
                    if (!st_go && frame_tick && ride_en)
                        n_x = ride_x[11] ? 10'd0 : ride_x > ride_max ? ride_max[9:0] : ride_x[9:0];
                end
                HOP: begin
                    if (hop_done) begin
                        n_x   = tx;
                        n_y   = ty;
                        n_fc  = '0;
                        n_hop = 1'b0;
                        n_cur = IDLE;
                        if (done_v) begin
                            n_face = done_d;
                            st_go  = legal(done_d, tx, ty, frog_size);
                            st_x   = tx;
                            st_y   = ty;
                            st_d   = done_d;
                        end
                    end else if (frame_tick) begin
                        n_fc = fcnt + 1'b1;
                        n_x  = hd == LEFT ? pos_x - STEP : hd == RIGHT ? pos_x + STEP : pos_x;
                        n_y  = hd == UP ? pos_y - STEP : hd == DOWN ? pos_y + STEP : pos_y;
                    end
                end
                RESPAWN: begin
                    if (frame_tick) begin
                        n_rc  = rcnt == LAST_R ? '0 : rcnt + 1'b1;
                        n_cur = rcnt == LAST_R ? IDLE : RESPAWN;
                    end
                end
                default: ;
            endcase
        end
        if (st_go) begin
            n_cur = HOP;
            n_hop = 1'b1;
            n_fc  = '0;
            n_hd  = st_d;
            n_tx  = st_d == LEFT ? st_x - B : st_d == RIGHT ? st_x + B : st_x;
            n_ty  = st_d == UP ? st_y - B : st_d == DOWN ? st_y + B : st_y;
        end
        n_end = n_cur == IDLE && n_y <= 10'(END_Y);
    end
endmodule

// File: tb/tb_hopper_ctrl.sv
// tb_hopper_ctrl: directed self-checking bench for hopper_ctrl.
module tb_hopper_ctrl;
    logic clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, collision = 1'b0, ride_en = 1'b0;
    logic [1:0] state = 2'd1;
    logic [9:0] init_x = 10'd320, init_y = 10'd448, frog_size = 10'd32;
    logic [3:0] dpad_input = 4'd0, ride_dx = 4'd0;
    logic [9:0] pos_x, pos_y;
    logic [1:0] facing, lives;
    logic hopping, reached_end, game_over;
    int errors = 0, checks = 0;

    localparam logic [1:0] F_UP = 2'd0, F_DOWN = 2'd1, F_LEFT = 2'd2, F_RIGHT = 2'd3;

    hopper_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .state(state),
        .init_x(init_x), .init_y(init_y), .frog_size(frog_size), .dpad_input(dpad_input),
        .collision(collision), .ride_en(ride_en), .ride_dx(ride_dx),
        .pos_x(pos_x), .pos_y(pos_y), .facing(facing), .hopping(hopping),
        .reached_end(reached_end), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(1);
        end
    endtask

    task automatic press(input int b);
        dpad_input[b] = 1'b1;
        step(12);
        dpad_input = 4'd0;
        step(12);
    endtask

    task automatic hit();
        collision = 1'b1;
        step(1);
        collision = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        do_reset();
        chk("rst_x", pos_x, 320);
        chk("rst_y", pos_y, 448);
        chk("rst_face", facing, F_UP);
        chk("rst_hop", hopping, 0);
        chk("rst_end", reached_end, 0);
        chk("rst_lives", lives, 3);
        chk("rst_go", game_over, 0);

        // up hop
        press(2);
        chk("up_hop", hopping, 1);
        chk("up_y0", pos_y, 448);
        frame(1); chk("up_y1", pos_y, 440);
        frame(1); chk("up_y2", pos_y, 432);
        frame(1); chk("up_y3", pos_y, 424);
        chk("up_hop3", hopping, 1);
        frame(1); chk("up_y4", pos_y, 416);
        chk("up_done", hopping, 0);

        // illegal moves at the left and bottom edges
        init_x = 10'd0;
        do_reset();
        press(0);
        chk("ill_face_l", facing, F_LEFT);
        chk("ill_x", pos_x, 0);
        chk("ill_hop_l", hopping, 0);
        press(1);
        chk("ill_face_d", facing, F_DOWN);
        chk("ill_hop_d", hopping, 0);
        chk("ill_y", pos_y, 448);
        press(3);
        chk("right_hop", hopping, 1);
        frame(4);
        chk("right_x", pos_x, 32);
        chk("right_face", facing, F_RIGHT);

        // collisions, respawn and game over
        init_x = 10'd320;
        do_reset();
        press(2);
        frame(2);
        chk("mid_y", pos_y, 432);
        hit();
        chk("hit_x", pos_x, 320);
        chk("hit_y", pos_y, 448);
        chk("hit_lives", lives, 2);
        chk("hit_hop", hopping, 0);
        hit();
        chk("resp_lives", lives, 2);
        press(2);
        chk("resp_nohop", hopping, 0);
        frame(29);
        press(2);
        chk("resp29_nohop", hopping, 0);
        frame(1);
        press(2);
        chk("resp30_hop", hopping, 1);
        hit();
        chk("hit2_lives", lives, 1);
        chk("hit2_go", game_over, 0);
        frame(30);
        hit();
        chk("hit3_lives", lives, 0);
        chk("hit3_go", game_over, 1);
        press(2);
        chk("go_nohop", hopping, 0);
        chk("go_y", pos_y, 448);
        do_reset();
        chk("rst2_lives", lives, 3);
        chk("rst2_go", game_over, 0);

        // presses discarded outside PLAYING
        state = 2'd0;
        press(2);
        state = 2'd1;
        step(1);
        chk("menu_nohop", hopping, 0);

        // riding with clamping
        init_x = 10'd4;
        do_reset();
        ride_en = 1'b1;
        ride_dx = 4'hD;
        frame(1); chk("ride_1", pos_x, 1);
        frame(1); chk("ride_0", pos_x, 0);
        frame(1); chk("ride_clamp0", pos_x, 0);
        init_x = 10'd606;
        ride_en = 1'b0;
        do_reset();
        ride_en = 1'b1;
        ride_dx = 4'd5;
        frame(1); chk("ride_max", pos_x, 608);
        frame(1); chk("ride_max2", pos_x, 608);
        ride_en = 1'b0;

        // press during a hop
        init_x = 10'd320;
        do_reset();
        press(2);
        frame(2);
        press(3);
        frame(2);
        chk("buf_y", pos_y, 416);
`ifdef HOPPER_BUFFER_EN
        chk("buf_hop", hopping, 1);
        chk("buf_face", facing, F_RIGHT);
        frame(4);
        chk("buf_x", pos_x, 352);
`else
        chk("buf_hop", hopping, 0);
        chk("buf_face", facing, F_UP);
        frame(4);
        chk("buf_x", pos_x, 320);
`endif

        // goal row and MENU freeze mid-hop
        init_y = 10'd32;
        do_reset();
        chk("goal_end0", reached_end, 0);
        press(2);
        frame(2);
        chk("goal_mid", pos_y, 16);
        chk("goal_mid_end", reached_end, 0);
        state = 2'd0;
        frame(10);
        chk("freeze_y", pos_y, 16);
        chk("freeze_hop", hopping, 1);
        state = 2'd1;
        frame(1); chk("resume_y", pos_y, 8);
        frame(1); chk("goal_y", pos_y, 0);
        chk("goal_hop", hopping, 0);
        chk("goal_end", reached_end, 1);
        press(2);
        chk("goal_top_nohop", hopping, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hopper_ctrl.md
HOPPER_CTRL -- requirements
Module: hopper_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- BLOCK, 32: grid step in pixels.
- HOP_FRAMES, 4: frames per animated hop; SHALL divide BLOCK.
- SCREEN_W, 640: playfield width.
- SCREEN_H, 480: playfield height.
- END_Y, 15: goal-row threshold.
- LIVES, 3: starting lives.
- RESPAWN_FRAMES, 30: frames frozen after a death.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), with one clock and a synchronous, active-high reset:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- frame_tick, in, 1: one-cycle pulse per video frame.
- state, in, 2: game state from the shared game_state_t.
- init_x, in, 10: spawn x.
- init_y, in, 10: spawn y.
- frog_size, in, 10: sprite edge in pixels.
- dpad_input, in, 4: raw buttons; bit0 left, bit1 down, bit2 up, bit3 right.
- collision, in, 1: hazard hit, level-sampled.
- ride_en, in, 1: standing on a moving platform.
- ride_dx, in, 4: signed pixels per frame while riding.
- pos_x, out, 10: sprite x.
- pos_y, out, 10: sprite y.
- facing, out, 2: face_dir_t.
- hopping, out, 1: hop animation in progress.
- reached_end, out, 1: goal reached.
- lives, out, $clog2(LIVES+1): remaining lives.
- game_over, out, 1: lives exhausted.

Function
REQ-003 Each dpad bit SHALL be debounced into a one-cycle press tick. Priority when several ticks coincide: up > down > left > right.
REQ-004 The controller SHALL use an FSM with states IDLE, HOP, RESPAWN, GAMEOVER.
REQ-005 Press handling in IDLE with state==PLAYING:
- Any press tick SHALL set facing to the pressed direction.
- A hop SHALL start (enter HOP, latch target = pos ± BLOCK on one axis, hopping=1) only if the move is legal.
- Legal moves: up if pos_y >= BLOCK; down if pos_y+BLOCK+frog_size <= SCREEN_H; left if pos_x >= BLOCK; right if pos_x+BLOCK+frog_size <= SCREEN_W.
- An illegal press SHALL turn the sprite only; it SHALL NOT start a hop.
REQ-006 In HOP, each frame_tick SHALL move pos by BLOCK/HOP_FRAMES toward the target.
- On the HOP_FRAMES-th tick, pos SHALL equal the target exactly.
- The FSM SHALL return to IDLE and clear hopping on that same cycle.
REQ-007 Riding in IDLE: each frame_tick with ride_en=1 SHALL add sign-extended ride_dx to pos_x, clamped to [0, SCREEN_W-frog_size]. Riding SHALL be ignored in HOP, and on a cycle where a hop starts.
REQ-008 reached_end SHALL be registered, SHALL be 1 in IDLE while pos_y <= END_Y, and 0 otherwise.
REQ-009 Collision in IDLE or HOP SHALL:
- decrement lives;
- set pos to init, facing to UP, and clear hopping;
- drop any buffered press;
- enter RESPAWN, or GAMEOVER if lives becomes 0.
REQ-010 In RESPAWN, the block SHALL ignore collision and presses, and SHALL return to IDLE after RESPAWN_FRAMES frame_ticks.
REQ-011 GAMEOVER SHALL assert game_over and hold all outputs until reset.
REQ-012 When state != PLAYING, the FSM, position and frame counters SHALL freeze, and press ticks SHALL be discarded. On return to PLAYING, the block SHALL resume mid-hop where it left off.
REQ-013 Simultaneous events:
- collision beats a press tick and hop completion;
- hop completion and a new press on the same cycle: the press SHALL be handled per REQ-017.

Reset
REQ-014 On reset, all outputs SHALL take these values on the next clock edge, regardless of the current FSM state:
- pos = init_x/init_y;
- facing = UP;
- hopping = 0, reached_end = 0;
- lives = LIVES, game_over = 0;
- FSM = IDLE; counters and the buffer cleared.
REQ-015 After power-up without reset, the first clock SHALL load init_x/init_y (self-initialise).

Configuration
REQ-016 Without HOPPER_BUFFER_EN, press ticks during HOP SHALL be discarded.
REQ-017 With HOPPER_BUFFER_EN, one press tick during HOP SHALL be stored; the first press wins and later presses are discarded.
- On hop completion, the stored press SHALL be evaluated per REQ-005 against the completed position.
- A legal stored press SHALL start the next hop on that same cycle, keeping hopping=1.

Structure
REQ-018 The shared package SHALL hold:
- game_state_t: MENU=0, PLAYING=1, DEAD=2, WIN=3;
- face_dir_t: UP=0, DOWN=1, LEFT=2, RIGHT=3;
- the hopper FSM state enum.
REQ-019 The block SHALL instantiate the existing debounce sub-module once per button. No other sub-modules SHALL be used.

Verification
REQ-020 Up hop: init (320,448), PLAYING, up tick → hopping=1; pos_y steps 440, 432, 424, 416 on 4 frame_ticks; then hopping=0.
REQ-021 Illegal move: pos_x=0, left tick → facing=LEFT, pos_x stays 0, no hop.
REQ-022 Collision mid-hop after 2 frame_ticks → pos=(320,448), lives 3→2, RESPAWN; collision during the 30 respawn frames does not change lives. Third collision → lives=0, game_over=1; reset → lives=3.
REQ-023 Riding: ride_en=1, ride_dx=-3, pos_x=4 → 1, then 0 (clamped); ride_dx=+5 near the right edge clamps to 640-frog_size.
REQ-024 HOPPER_BUFFER_EN: up tick, then a right tick at frame 2 → on completion the right hop starts the same cycle and hopping stays 1. Without the macro, the right press is lost.
REQ-025 Goal: hop to pos_y=0 → reached_end=1 after the hop ends. state=MENU mid-hop freezes pos for 10 frame_ticks; PLAYING resumes the hop.
